// File: rtl/fp_acc_pkg.sv
// fp_acc_pkg: widths, IEEE-754 single constants and FSM states shared by the FP accumulator.
package fp_acc_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRS_W = 3;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int FW = MAN_W + 1 + GRS_W;
  localparam int SW = FW + 1;
  localparam int XW = EXP_W + 2;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, WRITE} state_e;
  function automatic logic is_special(input logic [EXP_W-1:0] e);
    return e == EXP_W'(EXP_MAX);
  endfunction
endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: single-cycle right shifter; every bit shifted out is ORed into the result LSB (sticky).
module fp_align_shift
  import fp_acc_pkg::*;
#(
  parameter int W = FW,
  parameter int SW = EXP_W
) (
  input  logic [W-1:0]  in_i,
  input  logic [SW-1:0] sh_i,
  output logic [W-1:0]  out_o
);
  logic [W-1:0] lost;
  logic big;
  assign big = sh_i >= SW'(W);
  assign lost = in_i & ~({W{1'b1}} << sh_i);
  assign out_o = big ? {{(W-1){1'b0}}, |in_i} : ((in_i >> sh_i) | {{(W-1){1'b0}}, |lost});
endmodule

// File: rtl/fp_mul_accumulator.sv
// fp_mul_accumulator: accumulates IEEE-754 single products via an unpack/align/add/normalise/write FSM.
// Define FPACC_RNE_EN for round-to-nearest-even on write-back; otherwise results truncate toward zero.
module fp_mul_accumulator
  import fp_acc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] acc,
  output logic        acc_valid,
  output logic        busy,
  output logic        ovf
);
  state_e state_q;
  logic [31:0] op_q, acc_q, res_q;
  logic acc_valid_q, ovf_q, skip_q, x_sgn_q, a_sgn_q, sub_q;
  logic [EXP_W-1:0] x_exp_q;
  logic [MAN_W:0] x_man_q;
  logic [XW-1:0] exp_q;
  logic [FW-1:0] a_man_q, b_man_q;
  logic [SW-1:0] sum_q;

  logic [EXP_W-1:0] y_exp, big_exp, small_exp;
  logic [MAN_W:0] y_man, big_man, small_man;
  logic [FW-1:0] b_shift;
  logic x_ge, special, inc, of_w;
  logic [MAN_W+1:0] man_r;
  logic [MAN_W-1:0] frac_r;
  logic [XW-1:0] exp_r;
  logic [31:0] packed_w;

  // The accumulator itself is the second operand; it never holds a denormal.
  assign y_exp = acc_q[30:23];
  assign y_man = {|y_exp, acc_q[22:0]};
  assign x_ge = {x_exp_q, x_man_q} >= {y_exp, y_man};
  assign big_exp = x_ge ? x_exp_q : y_exp;
  assign small_exp = x_ge ? y_exp : x_exp_q;
  assign big_man = x_ge ? x_man_q : y_man;
  assign small_man = x_ge ? y_man : x_man_q;
  assign special = is_special(op_q[30:23]);

  fp_align_shift #(.W(FW), .SW(EXP_W)) u_align (
    .in_i ({small_man, {GRS_W{1'b0}}}),
    .sh_i (big_exp - small_exp),
    .out_o(b_shift)
  );

`ifdef FPACC_RNE_EN
  assign inc = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
  assign inc = 1'b0;
`endif
  assign man_r = {1'b0, sum_q[SW-2:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
  assign exp_r = exp_q + {{(XW-1){1'b0}}, man_r[MAN_W+1]};
  assign frac_r = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
  assign of_w = sum_q[SW-2] && exp_q != '0 && exp_r >= XW'(EXP_MAX);
  assign packed_w = (!sum_q[SW-2] || exp_q == '0) ? 32'h0 :
                    of_w ? (a_sgn_q ? NEG_INF : POS_INF) :
                    {a_sgn_q, exp_r[EXP_W-1:0], frac_r};

  assign in_ready = (state_q == IDLE) && !clear;
  assign busy = state_q != IDLE;
  assign acc = acc_q;
  assign acc_valid = acc_valid_q;
  assign ovf = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      acc_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      skip_q <= 1'b0;
      x_sgn_q <= 1'b0;
      x_exp_q <= '0;
      x_man_q <= '0;
      a_sgn_q <= 1'b0;
      sub_q <= 1'b0;
      exp_q <= '0;
      a_man_q <= '0;
      b_man_q <= '0;
      sum_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= in_data;
          state_q <= UNPACK;
        end
        UNPACK: begin
          x_sgn_q <= op_q[31];
          x_exp_q <= op_q[30:23];
          x_man_q <= {|op_q[30:23], {MAN_W{|op_q[30:23]}} & op_q[22:0]};
          skip_q <= ovf_q | special;
          res_q <= ovf_q ? acc_q : |op_q[22:0] ? QNAN : op_q[31] ? NEG_INF : POS_INF;
          state_q <= (ovf_q | special) ? WRITE : ALIGN;
        end
        ALIGN: begin
          a_sgn_q <= x_ge ? x_sgn_q : acc_q[31];
          sub_q <= x_sgn_q ^ acc_q[31];
          exp_q <= {2'b00, big_exp};
          a_man_q <= {big_man, {GRS_W{1'b0}}};
          b_man_q <= b_shift;
          state_q <= ADD;
        end
        ADD: begin
          sum_q <= sub_q ? {1'b0, a_man_q} - {1'b0, b_man_q} : {1'b0, a_man_q} + {1'b0, b_man_q};
          state_q <= NORM;
        end
        NORM: begin
          if (sum_q == '0) begin
            exp_q <= '0;
            a_sgn_q <= 1'b0;
            state_q <= WRITE;
          end else if (sum_q[SW-1]) begin
            sum_q <= {1'b0, sum_q[SW-1:2], |sum_q[1:0]};
            exp_q <= exp_q + XW'(1);
            state_q <= WRITE;
          end else if (sum_q[SW-2]) begin
            state_q <= WRITE;
          end else if (exp_q == XW'(1)) begin
            exp_q <= '0;
            state_q <= WRITE;
          end else begin
            // One left shift per cycle; leave as soon as the hidden bit lands.
            sum_q <= sum_q << 1;
            exp_q <= exp_q - XW'(1);
            if (sum_q[SW-3]) state_q <= WRITE;
          end
        end
        WRITE: begin
          acc_q <= skip_q ? res_q : packed_w;
          ovf_q <= skip_q | of_w;
          acc_valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_accumulator.sv
// tb_fp_mul_accumulator: scoreboard bench; expected accumulator values are queued as operands are driven.
module tb_fp_mul_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, acc_valid, busy, ovf;
  logic [31:0] acc;
  int checks = 0, fails = 0;
  logic [31:0] sb[$];

  fp_mul_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .acc(acc), .acc_valid(acc_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic [31:0] val, output logic tail);
    lat = 0;
    while (!acc_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!acc_valid) lat = -1;
    val = acc;
    @(negedge clk);
    tail = acc_valid;
  endtask

  task automatic do_clear;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (acc !== 32'h0 || acc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset acc=%h v=%b rdy=%b busy=%b ovf=%b want 0/0/1/0/0", acc, acc_valid, in_ready, busy, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_accumulate;
    int lat; logic [31:0] got, want; logic tail;
    sb.push_back(32'h42908000); send(32'h42908000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5 || tail !== 1'b0) begin
      fails++; $display("FAIL acc_first acc=%h lat=%0d tail=%b want %h lat 5 tail 0", got, lat, tail, want);
    end
    sb.push_back(32'h43108000); send(32'h42908000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5 || tail !== 1'b0) begin
      fails++; $display("FAIL acc_double acc=%h lat=%0d tail=%b want %h lat 5 tail 0", got, lat, tail, want);
    end
  endtask

  task automatic test_cancel;
    int lat; logic [31:0] got, want; logic tail;
    sb.push_back(32'h42908000); send(32'hC2908000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5 || tail !== 1'b0) begin
      fails++; $display("FAIL cancel_sub acc=%h lat=%0d want %h lat 5", got, lat, want);
    end
    sb.push_back(32'h00000000); send(32'hC2908000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5) begin
      fails++; $display("FAIL cancel_zero acc=%h lat=%0d want %h lat 5", got, lat, want);
    end
  endtask

  task automatic test_round;
    int lat; logic [31:0] got, want, rnd; logic tail;
`ifdef FPACC_RNE_EN
    rnd = 32'h3F800001;
`else
    rnd = 32'h3F800000;
`endif
    do_clear();
    sb.push_back(32'h3F800000); send(32'h3F800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5) begin
      fails++; $display("FAIL round_seed acc=%h lat=%0d want %h", got, lat, want);
    end
    sb.push_back(rnd); send(32'h33C00000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5) begin
      fails++; $display("FAIL round_grs acc=%h lat=%0d want %h", got, lat, want);
    end
    sb.push_back(rnd); send(32'h30800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || lat != 5) begin
      fails++; $display("FAIL round_sticky acc=%h lat=%0d want %h", got, lat, want);
    end
  endtask

  task automatic test_overflow;
    int lat; logic [31:0] got, want; logic tail;
    do_clear();
    sb.push_back(32'h7F7FFFFF); send(32'h7F7FFFFF); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_max acc=%h ovf=%b want %h ovf 0", got, ovf, want);
    end
    sb.push_back(32'h7F800000); send(32'h7F7FFFFF); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || ovf !== 1'b1 || lat != 5) begin
      fails++; $display("FAIL ovf_inf acc=%h ovf=%b lat=%0d want %h ovf 1 lat 5", got, ovf, lat, want);
    end
    sb.push_back(32'h7F800000); send(32'h3F800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || ovf !== 1'b1 || lat != 2 || tail !== 1'b0) begin
      fails++; $display("FAIL ovf_hold acc=%h ovf=%b lat=%0d want %h ovf 1 lat 2", got, ovf, lat, want);
    end
    do_clear();
    checks++;
    if (acc !== 32'h0 || ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clear acc=%h ovf=%b want 0 ovf 0", acc, ovf);
    end
  endtask

  task automatic test_special;
    int lat; logic [31:0] got, want; logic tail;
    sb.push_back(32'h7FC00000); send(32'h7FC00001); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || ovf !== 1'b1 || lat != 2) begin
      fails++; $display("FAIL special_nan acc=%h ovf=%b lat=%0d want %h ovf 1 lat 2", got, ovf, lat, want);
    end
    do_clear();
    sb.push_back(32'hFF800000); send(32'hFF800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want || ovf !== 1'b1 || lat != 2) begin
      fails++; $display("FAIL special_ninf acc=%h ovf=%b lat=%0d want %h ovf 1 lat 2", got, ovf, lat, want);
    end
    do_clear();
  endtask

  task automatic test_norm_worst;
    int lat, low; logic [31:0] got, want; logic tail;
    do_clear();
    sb.push_back(32'h3F800000); send(32'h3F800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++; $display("FAIL norm_seed acc=%h want %h", got, want);
    end
    @(negedge clk);
    in_data = 32'hBF7FFFFF;
    in_valid = 1'b1;
    sb.push_back(32'h33800000);
    @(negedge clk);
    lat = 0;
    low = 0;
    while (!acc_valid && lat < 60) begin
      if (busy && !in_ready) low++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    got = acc;
    want = sb.pop_front();
    checks++;
    if (got !== want || lat != 28) begin
      fails++; $display("FAIL norm_worst acc=%h lat=%0d want %h lat 28", got, lat, want);
    end
    checks++;
    if (low != 28) begin
      fails++; $display("FAIL norm_ready_low busy-and-not-ready cycles=%0d want 28", low);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || acc_valid !== 1'b0) begin
      fails++; $display("FAIL norm_no_extra busy=%b v=%b want 0/0", busy, acc_valid);
    end
  endtask

  task automatic test_clear_abort;
    int lat, pulses; logic [31:0] got, want; logic tail;
    sb.push_back(32'h3F800000); send(32'h3F800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++; $display("FAIL abort_seed acc=%h want %h", got, want);
    end
    send(32'h42908000);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL abort_ready_during_clear rdy=%b want 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (acc !== 32'h0 || acc_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL abort_state acc=%h v=%b busy=%b rdy=%b want 0/0/0/1", acc, acc_valid, busy, in_ready);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (acc_valid) pulses++; end
    checks++;
    if (pulses != 0) begin
      fails++; $display("FAIL abort_no_pulse pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_clear_priority;
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL prio_ready rdy=%b want 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc !== 32'h0) begin
      fails++; $display("FAIL prio_no_transfer busy=%b acc=%h want 0/0", busy, acc);
    end
  endtask

  task automatic test_reset_mid;
    int lat, pulses; logic [31:0] got, want; logic tail;
    sb.push_back(32'h3F800000); send(32'h3F800000); wait_valid(lat, got, tail); want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++; $display("FAIL rst_seed acc=%h want %h", got, want);
    end
    send(32'hBF7FFFFF);
    for (int i = 0; i < 8; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rst_busy_before busy=%b want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc !== 32'h0 || acc_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL rst_async acc=%h v=%b rdy=%b busy=%b ovf=%b want 0/0/1/0/0", acc, acc_valid, in_ready, busy, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (acc_valid) pulses++; end
    checks++;
    if (pulses != 0 || acc !== 32'h0) begin
      fails++; $display("FAIL rst_no_pulse pulses=%0d acc=%h want 0/0", pulses, acc);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_cancel();
    test_round();
    test_overflow();
    test_special();
    test_norm_worst();
    test_clear_abort();
    test_clear_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
